// File: rtl/ripple_borrow_subtractor_seq.sv
// Sequential unsigned subtractor: resolves CHUNK bits per cycle with a rippled borrow
// and returns {borrow, A-B} through a valid/ready handshake on both sides.
module ripple_borrow_subtractor_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);

    // WIDTH must be a whole multiple of CHUNK.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ripple-borrow subtraction of one chunk; returns {borrow_out, difference}.
    function automatic logic [CHUNK:0] sub_chunk(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             bin
    );
        logic [CHUNK-1:0] d;
        logic             c;
        c = bin;
        d = {CHUNK{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = a[i] ^ b[i] ^ c;
            c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
        end
        return {c, d};
    endfunction

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               borrow_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   diff_r;
    logic               ready_r;
    logic               valid_r;
    logic               busy_r;
    logic [WIDTH:0]     result_r;

    logic [31:0]        base_s;
    logic [CHUNK-1:0]   chunk_a_s;
    logic [CHUNK-1:0]   chunk_b_s;
    logic [CHUNK:0]     chunk_res_s;
    logic [WIDTH-1:0]   diff_next_s;

    // Select the active chunk, subtract it, and merge its bits into the difference.
    always_comb begin
        base_s      = 32'(idx_r) * 32'(CHUNK);
        chunk_a_s   = CHUNK'(a_r >> base_s);
        chunk_b_s   = CHUNK'(b_r >> base_s);
        chunk_res_s = sub_chunk(chunk_a_s, chunk_b_s, borrow_r);
        diff_next_s = (diff_r & ~(CHUNK_MASK << base_s))
                    | (WIDTH'(chunk_res_s[CHUNK-1:0]) << base_s);
    end

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r  <= IDLE;
            idx_r    <= {IDX_W{1'b0}};
            borrow_r <= 1'b0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            ready_r  <= 1'b1;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            result_r <= {(WIDTH+1){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid && ready_r) begin
                        a_r      <= i_minuend;
                        b_r      <= i_subtrahend;
                        borrow_r <= 1'b0;
                        idx_r    <= {IDX_W{1'b0}};
                        diff_r   <= {WIDTH{1'b0}};
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= BUSY;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                BUSY: begin
                    diff_r   <= diff_next_s;
                    borrow_r <= chunk_res_s[CHUNK];
                    idx_r    <= idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        result_r <= {chunk_res_s[CHUNK], diff_next_s};
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= DONE;
                    end else begin
                        state_r  <= BUSY;
                    end
                end
                DONE: begin
                    // No accept here: o_ready only rises on the cycle after the handshake.
                    if (i_ready) begin
                        result_r <= {(WIDTH+1){1'b0}};
                        valid_r  <= 1'b0;
                        ready_r  <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        state_r  <= DONE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ready_r  <= 1'b1;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    result_r <= {(WIDTH+1){1'b0}};
                end
            endcase
        end
    end

    assign o_ready  = ready_r;
    assign o_valid  = valid_r;
    assign o_busy   = busy_r;
    assign o_result = result_r;

endmodule

// File: tb/tb_ripple_borrow_subtractor_seq.sv
// Self-checking bench: directed vector table, stall/reset corner sequences,
// and randomized traffic scored against an arithmetic reference queue.
module tb_ripple_borrow_subtractor_seq;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_minuend;
    logic [15:0] i_subtrahend;
    logic        o_valid;
    logic        i_ready;
    logic [16:0] o_result;
    logic        o_busy;

    int tests = 0;
    int fails = 0;

    ripple_borrow_subtractor_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_minuend   (i_minuend),
        .i_subtrahend(i_subtrahend),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = 16'((32'(a) + 32'h10000 - 32'(b)) % 32'h10000);
        return {(a < b), d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        lat = 0;
        while (!o_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!o_valid) begin
            fails++;
            tests++;
            $display("FAIL %s_timeout: got o_valid=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] b,
                           input logic [16:0] exp, input string name);
        int lat;
        @(negedge clk);
        check({name, "_ready"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_minuend = a; i_subtrahend = b; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_minuend = 16'hDEAD; i_subtrahend = 16'hBEEF;
        check({name, "_busy_result0"}, 32'(o_result), 32'd0);
        wait_valid(name, lat);
        check({name, "_latency"}, lat, 32'd4);
        check({name, "_result"}, 32'(o_result), 32'(exp));
        @(posedge clk); #1;
        check({name, "_ready_after"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int accepts;
        int cycles;
        logic [16:0] q[$];
        logic [16:0] e;
        localparam int NRAND = 3000;
        localparam int LIMIT = 60000;

        vecs[0] = '{16'h0005, 16'h0003, 17'h00002};
        vecs[1] = '{16'h0003, 16'h0005, 17'h1FFFE};
        vecs[2] = '{16'h0000, 16'h0001, 17'h1FFFF};
        vecs[3] = '{16'h1234, 16'h1234, 17'h00000};
        vecs[4] = '{16'hFFFF, 16'h0000, 17'h0FFFF};
        vecs[5] = '{16'h8000, 16'h0001, 17'h07FFF};
        vecs[6] = '{16'h00FF, 16'h0100, 17'h1FFFF};
        vecs[7] = '{16'hA5A5, 16'h5A5A, 17'h04B4B};

        // Reset, with requests held to show reset wins.
        i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        i_minuend = 16'h0001; i_subtrahend = 16'h0002;
        repeat (3) @(posedge clk);
        @(negedge clk);
        i_rst = 1'b0; i_valid = 1'b0;
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

        // Consumer stalls 10 cycles while a new request waits.
        @(negedge clk);
        i_valid = 1'b1; i_minuend = 16'h00F0; i_subtrahend = 16'h000F; i_ready = 1'b0;
        @(posedge clk); #1;
        i_minuend = 16'h0001; i_subtrahend = 16'h0002;
        wait_valid("stall", lat);
        check("stall_result", 32'(o_result), 32'h000E1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_hold_valid", 32'(o_valid), 32'd1);
            check("stall_hold_result", 32'(o_result), 32'h000E1);
            check("stall_hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_ready", 32'(o_ready), 32'd1);
        check("hs_valid", 32'(o_valid), 32'd0);
        check("hs_no_accept", 32'(o_busy), 32'd0);
        @(posedge clk); #1;
        check("next_accepted", 32'(o_busy), 32'd1);
        i_valid = 1'b0;
        wait_valid("stall_next", lat);
        check("stall_next_latency", lat, 32'd4);
        check("stall_next_result", 32'(o_result), 32'h1FFFF);
        @(posedge clk); #1;

        // Reset during the second BUSY cycle aborts the transaction.
        @(negedge clk);
        i_valid = 1'b1; i_minuend = 16'h1234; i_subtrahend = 16'h0100; i_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_result", 32'(o_result), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 32'(o_valid), 32'd0);
        end
        run_txn(16'h8000, 16'h0001, 17'h07FFF, "post_abort");

        // Random traffic with stalls on both sides, scored in order.
        accepts = 0;
        cycles  = 0;
        while ((accepts < NRAND || q.size() != 0) && cycles < LIMIT) begin
            @(negedge clk);
            cycles++;
            i_valid      = (accepts < NRAND) && ($urandom_range(0, 3) != 0);
            i_minuend    = 16'($urandom);
            i_subtrahend = 16'($urandom);
            i_ready      = ($urandom_range(0, 3) != 0);
            if (i_valid && o_ready) begin
                q.push_back(model(i_minuend, i_subtrahend));
                accepts++;
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious_result", 32'(o_valid), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rand_result", 32'(o_result), 32'(e));
                end
            end
            if (!o_valid)
                check("rand_idle_result0", 32'(o_result), 32'd0);
        end
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b0;
        check("rand_accept_count", accepts, NRAND);
        check("rand_pending", q.size(), 32'd0);
        check("rand_within_budget", 32'(cycles < LIMIT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
